// File: rtl/cla_pkg.sv
// Shared helpers for carry-look-ahead adder variants.
// Provides the derived group counts and elaboration-time legality checks
// for WIDTH/GROUP/STAGES combinations. No ports.
package cla_pkg;

    // Number of GROUP-bit look-ahead groups across the operand.
    function automatic int unsigned calc_ngroups(input int unsigned width,
                                                 input int unsigned group);
        return (group == 0) ? 0 : width / group;
    endfunction

    // Groups per pipeline stage.
    function automatic int unsigned calc_gps(input int unsigned width,
                                             input int unsigned group,
                                             input int unsigned stages);
        return (stages == 0) ? 0 : calc_ngroups(width, group) / stages;
    endfunction

    function automatic bit width_legal(input int unsigned width, input int unsigned group);
        return (group != 0) && (width != 0) && (width % group == 0);
    endfunction

    function automatic bit stages_legal(input int unsigned width,
                                        input int unsigned group,
                                        input int unsigned stages);
        int unsigned ng;
        ng = calc_ngroups(width, group);
        return (stages >= 1) && (stages <= ng) && (ng % stages == 0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit combinational carry-look-ahead group.
// Ports:
//   a, b  - group operand slices
//   c     - carry into the group
//   sum   - group sum slice
//   gg    - group generate (carry out independent of c)
//   gp    - group propagate (carry in passes through)
//   cout  - carry out of the group MSB
module cla_group #(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c,
    output logic [GROUP-1:0] sum,
    output logic             gg,
    output logic             gp,
    output logic             cout
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] carry;
    logic             prod;
    logic             acc;

    // Every bit carry is a flat sum of products of g/p and c, so there is no
    // bit-to-bit ripple inside the group.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        carry = '0;
        prod  = 1'b0;
        acc   = 1'b0;
        gg    = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            prod = c;
            for (int j = 0; j < i; j++) prod = prod & p[j];
            acc = prod;
            for (int j = 0; j < i; j++) begin
                prod = g[j];
                for (int k = j + 1; k < i; k++) prod = prod & p[k];
                acc = acc | prod;
            end
            carry[i] = acc;
        end
        for (int j = 0; j < GROUP; j++) begin
            prod = g[j];
            for (int k = j + 1; k < GROUP; k++) prod = prod & p[k];
            gg = gg | prod;
        end
        gp   = &p;
        cout = gg | (gp & c);
        sum  = p ^ carry;
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor with valid/ready handshakes.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake (in_ready = global enable)
//   a, b, cin, sub       - operands; sub=1 computes a-b and ignores cin
//   out_valid / out_ready- result handshake
//   sum, cout, ovf, zero - result and flags from the last stage registers
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned GROUP  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NGROUPS = calc_ngroups(WIDTH, GROUP);
    localparam int unsigned GPS     = calc_gps(WIDTH, GROUP, STAGES);
    localparam int unsigned SBITS   = GPS * GROUP;
    localparam int unsigned LAST    = STAGES - 1;

    if (!width_legal(WIDTH, GROUP) || !stages_legal(WIDTH, GROUP, STAGES)) begin : g_bad_params
        $error("pipelined_cla_adder: illegal WIDTH/GROUP/STAGES combination");
    end

    logic             en;
    logic [STAGES-1:0] valid_q, valid_src;
    logic [STAGES-1:0] carry_q, carry_d, c_src;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  grp_sum;
    logic              ovf_q, ovf_d;

    // Single global enable: the whole pipe holds while a result waits.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Per-stage sources: stage 0 sees the preprocessed inputs, later stages
    // see the registers of the stage before.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = WIDTH'({SBITS{1'b1}}) << (s * SBITS);
        if (s == 0) begin : g_first
            assign valid_src[s] = in_valid;
            assign a_src[s]     = a;
            assign b_src[s]     = sub ? ~b : b;
            assign c_src[s]     = sub | cin;
            assign sum_d[s]     = grp_sum & MASK;
        end else begin : g_later
            assign valid_src[s] = valid_q[s-1];
            assign a_src[s]     = a_q[s-1];
            assign b_src[s]     = b_q[s-1];
            assign c_src[s]     = carry_q[s-1];
            // Keep the lower sum bits finished by earlier stages.
            assign sum_d[s]     = (sum_q[s-1] & ~MASK) | (grp_sum & MASK);
        end
    end

    // Groups: within a stage, group carries are chained through GG/GP.
    for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
        localparam int unsigned S  = g / GPS;
        localparam int unsigned LO = g * GROUP;
        logic c_in, c_out, gg, gp;
        // Group cout equals the GG/GP chain value; the chain is used instead.
        logic unused_cout;

        if (g % GPS == 0) begin : g_head
            assign c_in = c_src[S];
        end else begin : g_chain
            assign c_in = g_grp[g-1].c_out;
        end
        assign c_out = gg | (gp & c_in);

        cla_group #(
            .GROUP(GROUP)
        ) u_grp (
            .a   (a_src[S][LO +: GROUP]),
            .b   (b_src[S][LO +: GROUP]),
            .c   (c_in),
            .sum (grp_sum[LO +: GROUP]),
            .gg  (gg),
            .gp  (gp),
            .cout(unused_cout)
        );

        if (g % GPS == GPS - 1) begin : g_tail
            assign carry_d[S] = c_out;
        end
    end

    // Overflow: carry into the MSB (recovered from p ^ sum) xor carry out.
    assign ovf_d = a_src[LAST][WIDTH-1] ^ b_src[LAST][WIDTH-1] ^ grp_sum[WIDTH-1]
                   ^ carry_d[LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
            end
        end else if (en) begin
            valid_q <= valid_src;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= a_src[s];
                b_q[s]   <= b_src[s];
                sum_q[s] <= sum_d[s];
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = carry_q[LAST];
    assign ovf       = ovf_q;
    // Gated by valid so the flag reads 0 while empty/reset.
    assign zero      = valid_q[LAST] & ~|sum_q[LAST];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (WIDTH=32, GROUP=4, STAGES=2),
// plus a short randomised stream checked against an arithmetic model.
module tb_pipelined_cla_adder;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned GROUP  = 4;
    localparam int unsigned STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(
        .WIDTH (WIDTH),
        .GROUP (GROUP),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {zero, ovf, cout, sum}
    function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mcin, input logic msub);
        logic [31:0] be;
        logic [32:0] r;
        logic        v;
        be = msub ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, be} + {32'd0, (msub | mcin)};
        v  = (ma[31] == be[31]) && (r[31] != ma[31]);
        return {(r[31:0] == 32'd0), v, r[32], r[31:0]};
    endfunction

    // One isolated op: checks 2-cycle latency and the result/flags.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tcin,
                          input logic tsub, input logic [31:0] esum, input logic ecout,
                          input logic eovf, input logic ezero, input string tag);
        @(negedge clk);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        cin      = tcin;
        sub      = tsub;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " early"}, out_valid, 1'b0);
        @(negedge clk);
        chk({tag, " valid"}, out_valid, 1'b1);
        chk({tag, " result"}, {zero, ovf, cout, sum}, {ezero, eovf, ecout, esum});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [34:0] exp_q[$];
    logic [34:0] exp_v;
    logic [31:0] held_sum;
    logic        held_valid;
    int          out_idx, in_idx, n_stall, seen, sent, got;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset sum", sum, 32'h0);
        chk("reset flags", {cout, ovf, zero}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle out_valid", out_valid, 1'b0);

        // Reset with two ops in flight
        in_valid = 1'b1; a = 32'h1; b = 32'h1;
        @(negedge clk);
        a = 32'h2; b = 32'h2;
        @(negedge clk);
        in_valid = 1'b0;
        chk("inflight out_valid", out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", out_valid, 1'b0);
        chk("async reset sum", sum, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flushed results", seen, 0);
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0,
               "first after reset");

        // Directed arithmetic
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1,
               "wrap to zero");
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0,
               "pos overflow");
        run_op(32'h00000005, 32'h00000003, 1'b1, 1'b0, 32'h00000009, 1'b0, 1'b0, 1'b0,
               "cin add");
        run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1,
               "neg overflow");
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0,
               "sub overflow");
        run_op(32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0,
               "sub borrow");

        // Back-to-back with a stall on cycles 3..5
        out_idx = 0; in_idx = 0; n_stall = 0; held_valid = 1'b0; held_sum = '0;
        for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (in_idx < 8);
            a         = 32'h0F0F0F0F + 32'(in_idx);
            b         = 32'(in_idx);
            cin       = 1'b0;
            sub       = 1'b0;
            #1;
            chk("b2b in_ready", in_ready, !(out_valid && !out_ready));
            if (held_valid) chk("b2b stall hold", sum, held_sum);
            held_valid = out_valid && !out_ready;
            held_sum   = sum;
            if (out_valid && !out_ready) n_stall++;
            if (out_valid && out_ready) begin
                chk($sformatf("b2b sum %0d", out_idx), sum, 32'h0F0F0F0F + 32'(2 * out_idx));
                out_idx++;
            end
            if (in_valid && in_ready) in_idx++;
        end
        chk("b2b count", out_idx, 8);
        chk("b2b stall cycles", n_stall, 3);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("b2b no duplicate", out_valid, 1'b0);

        // Randomised stream with random back-pressure
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 4000 && got < 300; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 300) && ($urandom_range(0, 4) != 0);
            a         = $urandom;
            b         = ($urandom_range(0, 3) == 0) ? a : $urandom;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            #1;
            chk("rand in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand spurious", out_valid, 1'b0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk($sformatf("rand op %0d", got), {zero, ovf, cout, sum}, exp_v);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                sent++;
            end
        end
        chk("rand count", got, 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor built from GROUP-bit CLA groups.
- The group chain is split across STAGES register stages, and the inter-stage carry is registered.
- Valid/ready handshakes on input and output.
- Datapath arithmetic primitive for wide-operand blocks (accumulators, address generators) that must close timing at widths where a flat 4-bit-style ripple of group carries would not.

Parameters:
- WIDTH, 32: operand/sum width in bits. Must be a multiple of GROUP.
- GROUP, 4: bits per CLA group.
- STAGES, 2: pipeline depth, equal to latency in cycles. NGROUPS = WIDTH/GROUP. Must satisfy 1 <= STAGES <= NGROUPS and NGROUPS % STAGES == 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in, ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the environment) clears all stage valid bits and all stage data registers. Outputs during reset: out_valid=0, sum=0, cout=0, ovf=0, zero=0, in_ready=1.
- Operand preprocessing in the input cycle:
  - b_eff = sub ? ~b : b
  - c0 = sub ? 1 : cin
- Within each group: G = a&b_eff, P = a^b_eff. Group carries use full look-ahead (no ripple inside a group). Group-level GG/GP are chained across the GPS = NGROUPS/STAGES groups handled in one stage.
- Stage k (0-based) computes sum bits for groups k*GPS .. (k+1)*GPS-1 using the carry registered from stage k-1 (stage 0 uses c0).
- Each stage registers: its sum slice, carry-out, untouched upper operand bits for later stages, and the already-computed lower sum bits.
- Latency: a transfer accepted at edge N (in_valid && in_ready) gives out_valid=1 with its result after edge N+STAGES-1, i.e. visible from the cycle after edge N+STAGES-1. Throughput is one op per cycle when out_ready=1.
- Stall rule, global enable: en = !out_valid || out_ready; in_ready = en.
  - When en=0, every stage register holds and no stage valid changes.
  - Bubbles are not collapsed during stall.
- Output and flags:
  - Flags and sum are taken from the last stage's registers and held stable while out_valid && !out_ready.
  - cout = final carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero derived from the full registered sum.
- The result transfers on out_valid && out_ready.
- In a cycle where the result is taken and a new input is accepted simultaneously, both occur. There is no lost or duplicated result.
- Operands presented with in_valid=0 are ignored; the stage valid is 0 and data is don't-care (data registers may load).
- Result order equals acceptance order.
- Asserting rst_n=0 mid-operation discards all in-flight ops immediately. The first accepted op after reset is the first op output.
- STAGES=1: purely registered single-cycle adder with the same handshake.

Decomposition:
- Shared package (e.g. cla_pkg): localparams NGROUPS and GPS, plus elaboration-time legality check functions (WIDTH%GROUP, NGROUPS%STAGES). Usable by future CLA variants.
- Sub-module cla_group: GROUP-bit combinational CLA.
  - Inputs: a, b, c.
  - Outputs: sum, group generate GG, group propagate GP, cout.
  - Instantiated NGROUPS times via generate. All pipeline and handshake logic stays in the top.

Test Plan (WIDTH=32, GROUP=4, STAGES=2, out_ready=1 unless stated):
1. Reset then idle: out_valid=0, in_ready=1, sum=0. Assert rst_n=0 with 2 ops in flight: out_valid drops to 0 immediately, and neither result ever appears.
2. a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 accepted at edge N -> out_valid=1 after edge N+1 with sum=0x00000000, cout=1, ovf=0, zero=1.
3. a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1, zero=0. a=0x00000005, b=0x00000003, cin=1 -> sum=0x00000009.
4. Subtract, a=0x80000000, b=0x00000001, sub=1, cin=1 (ignored) -> sum=0x7FFFFFFF, cout=1, ovf=1. Second subtract, a=3, b=5, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
5. Back-to-back 8 ops (i+0x0F0F0F0F, i) with out_ready low for cycles 3-5 -> in_ready=0 exactly while out_valid && !out_ready; all 8 results correct, in order, with no duplicates. sum is held stable during the stall.
6. Random 10k ops across STAGES in {1,2,4,8} vs a reference model -> every sum/cout/ovf/zero matches; latency equals STAGES.
